// File: rtl/demux_dispatcher_pkg.sv
// rtl/demux_dispatcher_pkg.sv - shared constants and state encoding for the demux dispatcher
package demux_dispatcher_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    STALL = 2'd2
  } state_t;

endpackage

// File: rtl/demux_dispatcher_rr_pick.sv
// rtl/demux_dispatcher_rr_pick.sv - round-robin picker: first set mask bit at or after start, wrapping
module rr_pick
  import demux_dispatcher_pkg::*;
(
  input  logic [NUM_OUT-1:0] mask,
  input  logic [SEL_W-1:0]   start,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  // Scan from the farthest offset back to the nearest so the nearest enabled channel wins.
  always_comb begin
    logic [SEL_W-1:0] cand;
    cand  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      cand = start + SEL_W'(i);
      if (mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_dispatcher.sv
// rtl/demux_dispatcher.sv - one-word demux dispatching round-robin over enabled channels (optional stats: DEMUX_DISPATCHER_STATS_EN)
module demux_dispatcher
  import demux_dispatcher_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [NUM_OUT-1:0] chan_en,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [SEL_W-1:0]   out_sel
`ifdef DEMUX_DISPATCHER_STATS_EN
  ,
  output logic [15:0]        xfer_cnt,
  output logic [7:0]         reroute_cnt
`endif
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [7:0]          wait_q, wait_d, wait_inc;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [NUM_OUT-1:0]  sel_oh, pick_mask;
  logic [SEL_W-1:0]    pick_start, pick_idx;
  logic                pick_found;
  logic                xfer, reroute;

  // A single picker serves both the fresh pick (from ptr) and re-picks (from sel+1, excluding sel).
  always_comb begin
    sel_oh = 4'b0001 << sel_q;
    if (state_q == DRIVE) begin
      pick_mask  = chan_en & ~sel_oh;
      pick_start = sel_q + 1'b1;
    end else begin
      pick_mask  = chan_en;
      pick_start = ptr_q;
    end
  end

  rr_pick u_rr_pick (
    .mask  (pick_mask),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign out_data = hold_q;
  assign out_sel  = sel_q;

  // Next-state, handshake outputs and transfer/re-route decisions.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    wait_d    = wait_q;
    hold_d    = hold_q;
    in_ready  = 1'b0;
    out_valid = '0;
    wait_inc  = (wait_q == 8'hFF) ? 8'hFF : wait_q + 8'd1;

    if (state_q == DRIVE) out_valid = sel_oh & chan_en;
    xfer    = (out_valid & out_ready) != '0;
    reroute = (state_q == DRIVE) && chan_en[sel_q] && !out_ready[sel_q]
              && (wait_inc >= TIMEOUT_C) && pick_found;

    case (state_q)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          hold_d = in_data;
          wait_d = '0;
          if (pick_found) begin
            sel_d   = pick_idx;
            state_d = DRIVE;
          end else begin
            state_d = STALL;
          end
        end
      end
      DRIVE: begin
        if (!chan_en[sel_q]) begin
          // Channel withdrawn under us: move on, or park until something is enabled.
          wait_d = '0;
          if (pick_found) sel_d = pick_idx;
          else            state_d = STALL;
        end else if (xfer) begin
          ptr_d   = sel_q + 1'b1;
          wait_d  = '0;
          state_d = IDLE;
        end else if (reroute) begin
          sel_d  = pick_idx;
          wait_d = '0;
        end else if (wait_inc >= TIMEOUT_C) begin
          // Sole enabled channel: keep waiting on it with the counter pinned.
          wait_d = TIMEOUT_C;
        end else begin
          wait_d = wait_inc;
        end
      end
      STALL: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          wait_d  = '0;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and data registers; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      wait_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
    end
  end

`ifdef DEMUX_DISPATCHER_STATS_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;
  logic [7:0]  reroute_cnt_q, reroute_cnt_d;

  // Transfer count wraps; re-route count saturates.
  always_comb begin
    xfer_cnt_d    = xfer_cnt_q + {15'd0, xfer};
    reroute_cnt_d = (reroute && reroute_cnt_q != 8'hFF) ? reroute_cnt_q + 8'd1 : reroute_cnt_q;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q    <= '0;
      reroute_cnt_q <= '0;
    end else begin
      xfer_cnt_q    <= xfer_cnt_d;
      reroute_cnt_q <= reroute_cnt_d;
    end
  end

  assign xfer_cnt    = xfer_cnt_q;
  assign reroute_cnt = reroute_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_demux_dispatcher.sv
// tb/tb_demux_dispatcher.sv - scoreboard bench for demux_dispatcher (stats test under DEMUX_DISPATCHER_STATS_EN)
module tb_demux_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] chan_en = '0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
  logic [7:0] out_data;
  logic [1:0] out_sel;
`ifdef DEMUX_DISPATCHER_STATS_EN
  logic [15:0] xfer_cnt;
  logic [7:0]  reroute_cnt;
`endif

  demux_dispatcher #(.DATA_W(8), .TIMEOUT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .chan_en   (chan_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
`ifdef DEMUX_DISPATCHER_STATS_EN
    ,
    .xfer_cnt    (xfer_cnt),
    .reroute_cnt (reroute_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] d;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   stall_cycles  = 0;
  int   forbid_cycles = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((out_valid & out_ready) != 4'b0) begin
        if (sb_q.size() == 0) begin
          chk_eq("spurious_xfer", 32'(out_valid), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk_eq("xfer_chan", 32'(out_sel), 32'(mon_e.ch));
          chk_eq("xfer_onehot", 32'(out_valid), 32'(1 << mon_e.ch));
          chk_eq("xfer_data", 32'(out_data), 32'(mon_e.d));
        end
      end else if (out_valid != 4'b0) begin
        stall_cycles++;
      end
      if ((out_valid & 4'b0101) != 4'b0) forbid_cycles++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // Offer one word; ch < 0 means the word is not expected to be delivered.
  task automatic send(input logic [7:0] d, input int ch, input logic [3:0] lat_ov);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 200) begin
      step(1);
      n++;
    end
    if (!in_ready) chk_eq("in_ready_wait", 32'(in_ready), 32'd1);
    if (ch >= 0) begin
      e.ch = ch;
      e.d  = d;
      sb_q.push_back(e);
    end
    in_valid = 1'b1;
    in_data  = d;
    step(1);
    in_valid = 1'b0;
    chk_eq("latency_ov", 32'(out_valid), 32'(lat_ov));
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < max) begin
      step(1);
      n++;
    end
    chk_eq("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int t0;
    #1;
    chk_eq("rst_in_ready", 32'(in_ready), 32'd0);
    chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_out_sel", 32'(out_sel), 32'd0);
    chk_eq("rst_out_data", 32'(out_data), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Round robin over all four channels.
    chan_en   = 4'b1111;
    out_ready = 4'b1111;
    for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), i % 4, 4'(1 << (i % 4)));
    drain(20);

    // Masked channels 0 and 2.
    do_reset();
    chan_en = 4'b1010;
    t0 = forbid_cycles;
    send(8'h11, 1, 4'b0010);
    send(8'h12, 3, 4'b1000);
    send(8'h13, 1, 4'b0010);
    drain(20);
    chk_eq("masked_never_valid", 32'(forbid_cycles - t0), 32'd0);

    // Timeout re-route from channel 0 to channel 1.
    do_reset();
    chan_en   = 4'b0011;
    out_ready = 4'b0010;
    t0 = stall_cycles;
    send(8'h5C, 1, 4'b0001);
    drain(20);
    chk_eq("timeout_stall_cycles", 32'(stall_cycles - t0), 32'd3);
    out_ready = 4'b1111;
    send(8'h5D, 0, 4'b0001);
    drain(20);

    // Sole enabled channel keeps the word past the timeout.
    chan_en   = 4'b0001;
    out_ready = 4'b0000;
    send(8'h31, 0, 4'b0001);
    step(8);
    chk_eq("single_hold_ov", 32'(out_valid), 32'h1);
    out_ready = 4'b0001;
    drain(20);

    // Channel enable withdrawn while driving.
    chan_en   = 4'b0011;
    out_ready = 4'b0000;
    send(8'h3A, 0, 4'b0010);
    step(1);
    chan_en = 4'b0001;
    #1;
    chk_eq("drop_ov_now", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    chk_eq("drop_repick_ov", 32'(out_valid), 32'h1);
    out_ready = 4'b1111;
    drain(20);

    // No channel enabled: park in STALL until one appears.
    do_reset();
    chan_en = 4'b0000;
    send(8'h77, 2, 4'b0000);
    chk_eq("stall_in_ready", 32'(in_ready), 32'd0);
    step(2);
    chk_eq("stall_in_ready_hold", 32'(in_ready), 32'd0);
    chk_eq("stall_out_valid", 32'(out_valid), 32'd0);
    chan_en = 4'b0100;
    step(1);
    chk_eq("stall_release_ov", 32'(out_valid), 32'h4);
    drain(20);

    // Reset in the middle of DRIVE drops the held word.
    chan_en   = 4'b1111;
    out_ready = 4'b0000;
    send(8'h99, -1, 4'b1000);
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    chk_eq("midrst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    step(1);
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    step(4);
    chk_eq("midrst_no_delivery", 32'(out_valid), 32'd0);
    send(8'h42, 0, 4'b0001);
    drain(20);

`ifdef DEMUX_DISPATCHER_STATS_EN
    do_reset();
    chan_en   = 4'b0011;
    out_ready = 4'b0010;
    send(8'hE0, 1, 4'b0001);
    drain(20);
    chk_eq("reroute_cnt", 32'(reroute_cnt), 32'd1);
    chan_en   = 4'b0001;
    out_ready = 4'b0001;
    for (int i = 0; i < 65534; i++) begin
      send(8'(i), 0, 4'b0001);
    end
    drain(20);
    chk_eq("xfer_cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
    send(8'hEE, 0, 4'b0001);
    drain(20);
    chk_eq("xfer_cnt_wrap", 32'(xfer_cnt), 32'd0);
    chk_eq("reroute_cnt_final", 32'(reroute_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/demux_dispatcher.md
DEMUX_DISPATCHER -- requirements
Module: demux_dispatcher

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data word width.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the stall cycles tolerated before re-routing; the legal range is 1..255.
REQ-003 The block SHALL have port clk, input, width 1, the single clock; all flops are rising-edge.
REQ-004 The block SHALL have port rst_n, input, width 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, width 1, meaning the upstream word is valid.
REQ-006 The block SHALL have port in_ready, output, width 1, meaning the block accepts a word this cycle.
REQ-007 The block SHALL have port in_data, input, width DATA_W, carrying the upstream word.
REQ-008 The block SHALL have port chan_en, input, width 4, a per-output enable mask.
REQ-009 The block SHALL have port out_valid, output, width 4, one-hot or zero, the per-channel valid.
REQ-010 The block SHALL have port out_ready, input, width 4, the per-channel ready.
REQ-011 The block SHALL have port out_data, output, width DATA_W, shared by all channels and meaningful only where out_valid is set.
REQ-012 The block SHALL have port out_sel, output, width 2, giving the index of the channel being driven.

Function
REQ-013 The block SHALL implement the states IDLE, DRIVE and STALL: one holding register, round-robin distribution over enabled channels.
REQ-014 In IDLE: in_ready=1 and out_valid=0.
- When in_valid=1, the block SHALL capture in_data.
- It SHALL pick sel as the first enabled channel at or after ptr, with modulo-4 wrap.
- If chan_en!=0 it SHALL go to DRIVE; otherwise it SHALL go to STALL.
REQ-015 In DRIVE: in_ready=0, out_valid=(1<<sel) masked by chan_en[sel], out_data=the held word, out_sel=sel.
REQ-016 A transfer occurs when out_valid[sel]=1 and out_ready[sel]=1 in the same cycle.
- On a transfer, ptr SHALL be set to sel+1 (mod 4), wait_cnt SHALL clear, and the state SHALL return to IDLE.
REQ-017 Latency SHALL be one cycle: a word accepted at edge N is driven on out_valid from cycle N+1. Peak throughput SHALL be 1 word per 2 cycles.
REQ-018 In DRIVE without a transfer, wait_cnt (8 bit, saturating) SHALL increment.
- When wait_cnt reaches TIMEOUT and another enabled channel exists, sel SHALL re-pick from sel+1 and wait_cnt SHALL clear.
- The held word SHALL never be dropped.
REQ-019 If chan_en[sel] drops while in DRIVE, out_valid SHALL go to 0 in that cycle.
- Next edge: re-pick from sel+1 if chan_en!=0; otherwise go to STALL.
REQ-020 In STALL: out_valid=0 and in_ready=0. The first cycle with chan_en!=0 SHALL pick from ptr and go to DRIVE.
REQ-021 If TIMEOUT expires and sel is the only enabled channel, the block SHALL stay in DRIVE on sel, with wait_cnt held at TIMEOUT.
REQ-022 ptr SHALL advance only on a transfer, never on a re-route.

Reset
REQ-023 While rst_n=0, these SHALL hold immediately, independent of clk:
- state=IDLE, ptr=0, sel=0, wait_cnt=0, holding register=0;
- out_valid=0, out_sel=0, out_data=0, in_ready=0.
REQ-024 After rst_n deasserts, in_ready SHALL be 1 from the first clock.
- A reset asserted mid-DRIVE SHALL discard the held word.

Configuration
REQ-025 With macro DEMUX_DISPATCHER_STATS_EN defined, the block SHALL add outputs xfer_cnt (16 bit, increments per transfer, wraps 0xFFFF->0) and reroute_cnt (8 bit, saturating at 0xFF).
- Both counters SHALL reset to 0.
REQ-026 Without DEMUX_DISPATCHER_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 Package demux_dispatcher_pkg SHALL hold:
- constants NUM_OUT=4 and SEL_W=2;
- the state enum (IDLE, DRIVE, STALL).
REQ-028 Combinational sub-module rr_pick SHALL take a 4-bit mask and a 2-bit start, and return a 2-bit index plus a found flag.
- It SHALL be used for both the initial pick and re-picks.

Verification
REQ-029 The bench SHALL cover round robin: chan_en=4'b1111, all out_ready=1, words 0xA0..0xA5. Required: channels 0,1,2,3,0,1 in order, each out_valid one cycle after acceptance.
REQ-030 The bench SHALL cover a masked channel: chan_en=4'b1010 with 3 words. Required: channels 1,3,1; out_valid[0] and out_valid[2] never set.
REQ-031 The bench SHALL cover timeout: TIMEOUT=3, chan_en=4'b0011, out_ready[0]=0. Required: word 0x5C re-routes to channel 1 after 3 stall cycles and transfers; ptr then points to 2, and the next pick is channel 0.
REQ-032 The bench SHALL cover no channel enabled: chan_en=0, word 0x77 accepted. Required: STALL with in_ready=0.
- Set chan_en=4'b0100: 0x77 is delivered on channel 2 the next cycle.
REQ-033 The bench SHALL cover mid-operation reset: pull rst_n low while in DRIVE with out_ready=0. Required: out_valid=0 immediately, no delivery after release, first post-reset word goes to channel 0.
REQ-034 With DEMUX_DISPATCHER_STATS_EN, the bench SHALL cover counters: preload xfer_cnt=0xFFFF via 65535 transfers, then send one more. Required: xfer_cnt=0, and reroute_cnt matches the forced timeouts.
